// File: rtl/timer_ctrl.sv
// Control FSM for the mm:ss countdown timer: button edge detection, preset check, load/CE strobes.
// Optional blinking alarm in DONE when TIMER_ALARM_BLINK_EN is defined.
module timer_ctrl #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       load_btn,
  input  logic [3:0] I1,
  input  logic [3:0] I0,
  input  logic       done,
  input  logic       err,
  output logic       load,
  output logic       CE,
  output logic [2:0] mode,
  output logic       alarm,
  output logic       bad_input
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PresMax = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoading = 3'd1,
    StArmed   = 3'd2,
    StRun     = 3'd3,
    StPause   = 3'd4,
    StDone    = 3'd5,
    StFault   = 3'd6
  } state_e;

  state_e state_q, state_d;
  logic [PW-1:0] pres_q, pres_d;
  logic load_q;

  // Button bit order: {load_btn, pause, start}
  logic [2:0] btn_s1_q, btn_s2_q, btn_prev_q, btn_edge;
  logic start_e, pause_e, load_e;
  logic preset_bad;
  state_e preset_st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_prev_q <= '0;
    end else begin
      btn_s1_q   <= {load_btn, pause, start};
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
    end
  end

  assign btn_edge = btn_s2_q & ~btn_prev_q;
  assign start_e  = btn_edge[0];
  assign pause_e  = btn_edge[1];
  assign load_e   = btn_edge[2];

  assign preset_bad = (I1 > 4'd9) || (I0 > 4'd9) || ({I1, I0} == 8'h00);
  assign preset_st  = preset_bad ? StFault : StLoading;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (load_e) state_d = preset_st;
      StLoading: state_d = StArmed;
      StArmed: begin
        if (load_e)       state_d = preset_st;
        else if (start_e) state_d = StRun;
      end
      StRun: begin
        if (err)          state_d = StFault;
        else if (done)    state_d = StDone;
        else if (pause_e) state_d = StPause;
      end
      StPause: begin
        if (load_e)       state_d = preset_st;
        else if (start_e) state_d = StRun;
      end
      StDone, StFault: begin
        if (load_e)       state_d = preset_st;
        else if (pause_e) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Prescaler advances only in RUN (including the exit cycle) and holds elsewhere.
  always_comb begin
    pres_d = pres_q;
    if (state_q == StRun) begin
      pres_d = (pres_q == PresMax) ? '0 : pres_q + PW'(1);
    end else if (state_q == StArmed && state_d == StRun) begin
      pres_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pres_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pres_q  <= pres_d;
      load_q  <= (state_d == StLoading);
    end
  end

`ifdef TIMER_ALARM_BLINK_EN
  localparam int unsigned BlinkDiv = TICK_DIV / 4;
  localparam int unsigned BW = $clog2(BlinkDiv);
  localparam logic [BW-1:0] BlinkMax = BW'(BlinkDiv - 1);

  logic [BW-1:0] blink_cnt_q;
  logic blink_on_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
    end else if (state_d == StDone && state_q != StDone) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (state_q == StDone) begin
      if (blink_cnt_q == BlinkMax) begin
        blink_cnt_q <= '0;
        blink_on_q  <= ~blink_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  always_comb alarm = (state_q == StDone) && blink_on_q;
`else
  always_comb alarm = (state_q == StDone);
`endif

  always_comb begin
    mode      = state_q;
    load      = load_q;
    CE        = (state_q == StRun) && (pres_q == PresMax);
    bad_input = (state_q == StFault);
  end

endmodule
